stream_sync_packer: RTL

- RX-side counterpart of the TX width/serialisation stage.
- Takes narrow demodulated symbol chunks (MSB-first, e.g. 1 bit per beat) and hunts for a sync word.
- After sync, packs the following symbols MSB-first into OUT_WIDTH words.
- Emits exactly FRAME_WORDS words per frame, with out_last on the final word, then re-hunts. Sits between demodulator and byte-level frame consumer.

---
 rtl/stream_sync_pkg.sv | 14 +
 rtl/stream_sync_packer_correlator.sv | 39 +++
 rtl/stream_sync_packer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/stream_sync_pkg.sv
// Shared types and helpers for the sync-hunting symbol packer.
// Optional STREAM_SYNC_PACKER_INV_EN adds inverted-sync lock.
package stream_sync_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        PACK = 1'b1
    } sync_state_t;

    function automatic int smax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stream_sync_packer_correlator.sv
// Sync-word shift register with a compare on its next value.
// STREAM_SYNC_PACKER_INV_EN adds an inverted-pattern match.
module sync_correlator
    import stream_sync_pkg::*;
#(
    parameter int                  IN_WIDTH     = 1,
    parameter int                  SYNC_LEN     = 32,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 32'h1ACFFC1D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_i,
    input  logic                clear_i,
    input  logic [IN_WIDTH-1:0] data_i,
`ifdef STREAM_SYNC_PACKER_INV_EN
    output logic                match_inv_o,
`endif
    output logic                match_o
);

    logic [SYNC_LEN-1:0] sr_q;
    logic [SYNC_LEN-1:0] sr_d;

    assign sr_d    = SYNC_LEN'({sr_q, data_i});
    assign match_o = shift_i & (sr_d == SYNC_PATTERN);

`ifdef STREAM_SYNC_PACKER_INV_EN
    assign match_inv_o = shift_i & (sr_d == ~SYNC_PATTERN);
`endif

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            sr_q <= '0;
        end else if (shift_i) begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/stream_sync_packer.sv
// Hunts for a sync word, then packs FRAME_WORDS words MSB-first.
// Optional STREAM_SYNC_PACKER_INV_EN: lock on ~sync and invert payload.
module stream_sync_packer
    import stream_sync_pkg::*;
#(
    parameter int                  IN_WIDTH     = 1,
    parameter int                  OUT_WIDTH    = 8,
    parameter int                  SYNC_LEN     = 32,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 32'h1ACFFC1D,
    parameter int                  FRAME_WORDS  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
`ifdef STREAM_SYNC_PACKER_INV_EN
    output logic                 inverted,
`endif
    output logic                 locked
);

    localparam int RATE = OUT_WIDTH / IN_WIDTH;
    localparam int SW   = smax($clog2(RATE), 1);
    localparam int WW   = smax($clog2(FRAME_WORDS), 1);

    if ((OUT_WIDTH % IN_WIDTH) != 0) begin : g_bad_out
        $error("OUT_WIDTH must be a multiple of IN_WIDTH");
    end
    if ((SYNC_LEN % IN_WIDTH) != 0) begin : g_bad_sync
        $error("SYNC_LEN must be a multiple of IN_WIDTH");
    end
    if (FRAME_WORDS < 1) begin : g_bad_frame
        $error("FRAME_WORDS must be at least 1");
    end

    sync_state_t          state_q;
    logic [OUT_WIDTH-1:0] pk_q;
    logic [OUT_WIDTH-1:0] pk_d;
    logic [SW-1:0]        sym_q;
    logic [WW-1:0]        word_q;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic                 out_last_q;
    logic                 locked_q;
    logic [IN_WIDTH-1:0]  din;
    logic                 beat;
    logic                 hunt_shift;
    logic                 sym_wrap;
    logic                 frame_end;
    logic                 match;
    logic                 match_any;

    // HUNT never stalls; PACK stalls while a word is still unclaimed.
    assign in_ready = ~rst & ((state_q == HUNT) | ~out_valid_q | out_ready);

    assign beat       = in_valid & in_ready;
    assign hunt_shift = beat & (state_q == HUNT);
    assign sym_wrap   = beat & (state_q == PACK) & (sym_q == SW'(RATE - 1));
    assign frame_end  = sym_wrap & (word_q == WW'(FRAME_WORDS - 1));

`ifdef STREAM_SYNC_PACKER_INV_EN
    logic inv_q;
    logic match_inv;

    assign din       = in_data ^ {IN_WIDTH{inv_q}};
    assign match_any = match | match_inv;
    assign inverted  = inv_q;
`else
    assign din       = in_data;
    assign match_any = match;
`endif

    assign pk_d = OUT_WIDTH'({pk_q, din});

    sync_correlator #(
        .IN_WIDTH     (IN_WIDTH),
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_corr (
        .clk         (clk),
        .rst         (rst),
        .shift_i     (hunt_shift),
        .clear_i     (frame_end),
        .data_i      (in_data),
`ifdef STREAM_SYNC_PACKER_INV_EN
        .match_inv_o (match_inv),
`endif
        .match_o     (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            pk_q        <= '0;
            sym_q       <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            locked_q    <= 1'b0;
`ifdef STREAM_SYNC_PACKER_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            unique case (state_q)
                HUNT: begin
                    if (match_any) begin
                        state_q  <= PACK;
                        sym_q    <= '0;
                        word_q   <= '0;
                        locked_q <= 1'b1;
`ifdef STREAM_SYNC_PACKER_INV_EN
                        inv_q    <= ~match;
`endif
                    end
                end
                PACK: begin
                    if (beat) begin
                        pk_q <= pk_d;
                        if (sym_wrap) begin
                            // A new word overrides the handshake clear above.
                            out_data_q  <= pk_d;
                            out_valid_q <= 1'b1;
                            out_last_q  <= frame_end;
                            sym_q       <= '0;
                            word_q      <= word_q + WW'(1);
                            if (frame_end) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
`ifdef STREAM_SYNC_PACKER_INV_EN
                                inv_q    <= 1'b0;
`endif
                            end
                        end else begin
                            sym_q <= sym_q + SW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign locked    = locked_q;

endmodule
